// File: rtl/usb_ram_reg.sv
// FT245 byte-stream front end for a small register RAM: 0x01 addr data writes a byte,
// and 0x02 addr reads a byte back. The read data is returned on the FT245 transmit path.
module usb_ram_reg #(
  parameter int ADDR_W      = 8,
  parameter int RD_LOW_CYC  = 3,
  parameter int RD_HIGH_CYC = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       FT_RXFn,
  input  logic       FT_TXEn,
  output logic       FT_RDn,
  output logic       FT_WR,
  input  logic [7:0] FT_DATA_In,
  output logic [7:0] FT_DATA_Out
);

  typedef enum logic [2:0] {IDLE, RD_LOW, RD_HIGH, PARSE, TX_WAIT, TX_HIGH, TX_REC} state_t;

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0]     RD_LOW_LAST  = 16'(RD_LOW_CYC - 1);
  localparam logic [15:0]     RD_HIGH_LAST = 16'(RD_HIGH_CYC - 1);
  localparam logic [15:0]     WR_HIGH_LAST = 16'(WR_HIGH_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST      = TO_W'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [1:0]        rxf_sync, txe_sync;
  logic              rxf_low, txe_low;
  logic [15:0]       phase_cnt;
  logic [TO_W-1:0]   idle_cnt;
  logic [1:0]        byte_idx;
  logic [7:0]        cmd, rx_byte, tx_data;
  logic [ADDR_W-1:0] addr, rx_addr;
  logic              tx_pending, data_setup;
  logic              mem_we, read_done;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];

  assign rxf_low   = ~rxf_sync[1];
  assign txe_low   = ~txe_sync[1];
  assign rx_addr   = ADDR_W'(rx_byte);
  assign mem_we    = (state == PARSE) && (byte_idx == 2'd2);
  assign read_done = (byte_idx == 2'd1) && (cmd == 8'h02);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxf_sync <= 2'b11;
      txe_sync <= 2'b11;
    end else begin
      rxf_sync <= {rxf_sync[0], FT_RXFn};
      txe_sync <= {txe_sync[0], FT_TXEn};
    end
  end

  // RAM has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      FT_RDn      <= 1'b1;
      FT_WR       <= 1'b0;
      FT_DATA_Out <= 8'h00;
      phase_cnt   <= '0;
      idle_cnt    <= '0;
      byte_idx    <= 2'd0;
      cmd         <= 8'h00;
      rx_byte     <= 8'h00;
      tx_data     <= 8'h00;
      addr        <= '0;
      tx_pending  <= 1'b0;
      data_setup  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (byte_idx != 2'd0) begin
            if (idle_cnt == TO_LAST) begin
              byte_idx <= 2'd0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          if (tx_pending) begin
            data_setup <= 1'b0;
            state      <= TX_WAIT;
          end else if (rxf_low) begin
            FT_RDn    <= 1'b0;
            phase_cnt <= '0;
            state     <= RD_LOW;
          end
        end
        RD_LOW: begin
          if (phase_cnt == RD_LOW_LAST) begin
            rx_byte   <= FT_DATA_In;
            FT_RDn    <= 1'b1;
            phase_cnt <= '0;
            state     <= RD_HIGH;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        RD_HIGH: begin
          if (phase_cnt == RD_HIGH_LAST) state <= PARSE;
          else phase_cnt <= phase_cnt + 1'b1;
        end
        PARSE: begin
          idle_cnt <= '0;
          case (byte_idx)
            2'd0: begin
              if (rx_byte == 8'h01 || rx_byte == 8'h02) begin
                cmd      <= rx_byte;
                byte_idx <= 2'd1;
              end
            end
            2'd1: begin
              addr <= rx_addr;
              if (cmd == 8'h02) begin
                tx_data    <= mem[rx_addr];
                tx_pending <= 1'b1;
                byte_idx   <= 2'd0;
              end else begin
                byte_idx <= 2'd2;
              end
            end
            default: byte_idx <= 2'd0;
          endcase
          // Chaining straight into the next read keeps the strobe period at low+high+1.
          if (!read_done && rxf_low) begin
            FT_RDn    <= 1'b0;
            phase_cnt <= '0;
            state     <= RD_LOW;
          end else begin
            state <= IDLE;
          end
        end
        TX_WAIT: begin
          if (!data_setup) begin
            if (txe_low) begin
              FT_DATA_Out <= tx_data;
              data_setup  <= 1'b1;
            end
          end else begin
            FT_WR     <= 1'b1;
            phase_cnt <= '0;
            state     <= TX_HIGH;
          end
        end
        TX_HIGH: begin
          if (phase_cnt == WR_HIGH_LAST) begin
            FT_WR <= 1'b0;
            state <= TX_REC;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        TX_REC: begin
          tx_pending <= 1'b0;
          data_setup <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_ram_reg.sv
// Scoreboard bench for usb_ram_reg: a host model feeds FT245 bytes, and a monitor checks
// each FT_WR pulse against queued expected bytes.
module tb_usb_ram_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       FT_RXFn, FT_TXEn;
  logic       FT_RDn, FT_WR;
  logic [7:0] FT_DATA_In, FT_DATA_Out;

  int checks = 0;
  int failures = 0;
  int rdFalls = 0;
  int wrPulses = 0;
  int overlaps = 0;
  int wrHigh = 0;
  logic       prevRd = 1'b1;
  logic [7:0] prevData = 8'h00;
  logic [7:0] setupData = 8'h00;
  logic [7:0] expQ [$];

  usb_ram_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .FT_RXFn    (FT_RXFn),
    .FT_TXEn    (FT_TXEn),
    .FT_RDn     (FT_RDn),
    .FT_WR      (FT_WR),
    .FT_DATA_In (FT_DATA_In),
    .FT_DATA_Out(FT_DATA_Out)
  );

  always #20 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: strobe bookkeeping and scoreboard comparison at each FT_WR pulse.
  always @(negedge clk) begin
    if (!FT_RDn && FT_WR) overlaps++;
    if (prevRd && !FT_RDn) rdFalls++;
    if (FT_WR) begin
      if (wrHigh == 0) begin
        setupData = prevData;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_tx", {24'h0, FT_DATA_Out}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("tx_setup_data", {24'h0, setupData}, {24'h0, expQ[0]});
        end
      end else begin
        checkOutput("tx_data_stable", {24'h0, FT_DATA_Out}, {24'h0, setupData});
      end
      wrHigh++;
    end else if (wrHigh != 0) begin
      wrPulses++;
      checkOutput("tx_pulse_width", wrHigh, 2);
      if (expQ.size() != 0) begin
        checkOutput("tx_data", {24'h0, FT_DATA_Out}, {24'h0, expQ.pop_front()});
      end
      wrHigh = 0;
    end
    prevRd   = FT_RDn;
    prevData = FT_DATA_Out;
  end

  // Host side of one FT245 byte: present data, wait for the read strobe, then retract RXF.
  task automatic applyStimulus(input logic [7:0] b, output int lat);
    int n;
    FT_DATA_In = b;
    FT_RXFn    = 1'b0;
    n = 0;
    while (FT_RDn && n < 100) begin @(negedge clk); n++; end
    lat = n;
    checkOutput("rd_start", {31'h0, FT_RDn}, 0);
    n = 0;
    while (!FT_RDn && n < 100) begin @(negedge clk); n++; end
    FT_RXFn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int len);
    int lat;
    applyStimulus(b0, lat);
    if (len > 1) applyStimulus(b1, lat);
    if (len > 2) applyStimulus(b2, lat);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || FT_WR) && n < 300) begin @(negedge clk); n++; end
    checkOutput("tx_drain", expQ.size(), 0);
    expQ.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, lowC, highC, lat, base, wrBase;
    rst_n = 1'b0; FT_RXFn = 1'b1; FT_TXEn = 1'b0; FT_DATA_In = 8'h00;
    #50;
    checkOutput("reset_rdn", {31'h0, FT_RDn}, 1);
    checkOutput("reset_wr", {31'h0, FT_WR}, 0);
    checkOutput("reset_dout", {24'h0, FT_DATA_Out}, 0);
    @(negedge clk); rst_n = 1'b1;

    repeat (30) @(negedge clk);
    checkOutput("idle_no_reads", rdFalls, 0);
    checkOutput("idle_no_writes", wrPulses, 0);

    // Continuous RXF with a non-command byte: steady 3-low / 3-high strobe.
    FT_DATA_In = 8'h19; FT_RXFn = 1'b0;
    n = 0;
    while (FT_RDn && n < 50) begin @(negedge clk); n++; end
    checkOutput("stream_start", {31'h0, FT_RDn}, 0);
    for (int p = 0; p < 3; p++) begin
      lowC = 0;
      while (!FT_RDn && lowC < 20) begin @(negedge clk); lowC++; end
      highC = 0;
      while (FT_RDn && highC < 20) begin @(negedge clk); highC++; end
      checkOutput("rd_low_width", lowC, 3);
      checkOutput("rd_high_width", highC, 3);
    end
    FT_RXFn = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("stream_no_writes", wrPulses, 0);

    sendFrame(8'h01, 8'h10, 8'hA5, 3);
    expQ.push_back(8'hA5);
    sendFrame(8'h02, 8'h10, 8'h00, 2);
    waitDrain();

    // Address extremes and a junk command byte ahead of a valid read.
    sendFrame(8'h01, 8'h05, 8'h33, 3);
    sendFrame(8'h01, 8'hFF, 8'hFF, 3);
    sendFrame(8'h01, 8'h00, 8'h5C, 3);
    expQ.push_back(8'hFF);
    sendFrame(8'h02, 8'hFF, 8'h00, 2);
    waitDrain();
    expQ.push_back(8'h5C);
    sendFrame(8'h02, 8'h00, 8'h00, 2);
    waitDrain();
    applyStimulus(8'h7E, lat);
    expQ.push_back(8'h33);
    sendFrame(8'h02, 8'h05, 8'h00, 2);
    waitDrain();
    checkOutput("data_after_tx", {24'h0, FT_DATA_Out}, 32'h33);

    // TX blocked: pending byte must hold off new reads until FT_TXEn drops.
    FT_TXEn = 1'b1;
    repeat (4) @(negedge clk);
    expQ.push_back(8'hA5);
    sendFrame(8'h02, 8'h10, 8'h00, 2);
    base = rdFalls; wrBase = wrPulses;
    FT_DATA_In = 8'h19; FT_RXFn = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("blocked_no_reads", rdFalls - base, 0);
    checkOutput("blocked_no_writes", wrPulses - wrBase, 0);
    FT_TXEn = 1'b0;
    waitDrain();
    n = 0;
    while (rdFalls == base && n < 30) begin @(negedge clk); n++; end
    checkOutput("reads_resume", {31'h0, rdFalls != base}, 1);
    FT_RXFn = 1'b1;
    repeat (20) @(negedge clk);

    // Partial frame abandoned by the idle timeout.
    sendFrame(8'h01, 8'h20, 8'h11, 3);
    sendFrame(8'h01, 8'h20, 8'h00, 2);
    repeat (1024 + 5) @(negedge clk);
    expQ.push_back(8'h11);
    sendFrame(8'h02, 8'h20, 8'h00, 2);
    waitDrain();

    // Asynchronous reset in the middle of a read drops the partial frame.
    sendFrame(8'h01, 8'h40, 8'h77, 3);
    sendFrame(8'h01, 8'h40, 8'h00, 2);
    FT_DATA_In = 8'h99; FT_RXFn = 1'b0;
    n = 0;
    while (FT_RDn && n < 50) begin @(negedge clk); n++; end
    checkOutput("pre_reset_rdn", {31'h0, FT_RDn}, 0);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rdn", {31'h0, FT_RDn}, 1);
    checkOutput("async_rst_wr", {31'h0, FT_WR}, 0);
    checkOutput("async_rst_dout", {24'h0, FT_DATA_Out}, 0);
    FT_RXFn = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(8'h02, lat);
    checkOutput("post_reset_latency_ok", {31'h0, (lat >= 3 && lat <= 4)}, 1);
    expQ.push_back(8'h77);
    applyStimulus(8'h40, lat);
    waitDrain();

    checkOutput("strobe_overlap", overlaps, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
